// File: rtl/ip_cu_pkg.sv
// Shared opcode codes and one-hot FSM encoding for the CU task sequencer.
package ip_cu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int S_IDLE = 0;
  localparam int S_INI  = 1;
  localparam int S_ONGO = 2;
  localparam int S_RDY  = 3;
  localparam int S_HALT = 4;
  localparam int S_END  = 5;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_INI  = 6'b000010,
    ST_ONGO = 6'b000100,
    ST_RDY  = 6'b001000,
    ST_HALT = 6'b010000,
    ST_END  = 6'b100000
  } state_t;

endpackage

// File: rtl/ip_cu_arb.sv
// Pending-trigger register with lowest-index-first dispatch; dispatch decision is combinational.
// Trigger capture never stalls; a bit leaves pend only in the cycle it is dispatched.
module ip_cu_arb
  import ip_cu_pkg::*;
#(
  parameter int  TSK_NUM = 10,
  localparam int ID_SZ   = (TSK_NUM > 1) ? $clog2(TSK_NUM) : 1
) (
  input  logic               pclk,
  input  logic               prst_n,
  input  logic [TSK_NUM-1:0] trg,
  input  logic               disp_go,
  input  logic               new_only,
  output logic [TSK_NUM-1:0] pend,
  output logic               disp_vld,
  output logic [ID_SZ-1:0]   disp_id
);

  logic [TSK_NUM-1:0] req;
  logic [TSK_NUM-1:0] disp_oh;

  // Preemption picks only among freshly arriving bits; otherwise the whole queue competes.
  always_comb begin
    req      = new_only ? trg : (pend | trg);
    disp_oh  = '0;
    disp_id  = '0;
    for (int i = TSK_NUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        disp_oh    = '0;
        disp_oh[i] = 1'b1;
        disp_id    = ID_SZ'(i);
      end
    end
    disp_vld = disp_go & (|req);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend | trg) & ~(disp_vld ? disp_oh : '0);
    end
  end

endmodule

// File: rtl/ip_cu_seq.sv
// CU task sequencer: steps cu_pc through per-task micro-programs with per-opcode ALU latency.
// Dispatch takes effect on the next edge; cu_stall freezes sequencing while triggers still queue.
module ip_cu_seq
  import ip_cu_pkg::*;
#(
  parameter int  TSK_NUM = 10,
  parameter int  PC_SZ   = 8,
  parameter int  PC_NUM  = 256,
  parameter int  ALU_SZ  = 16,
  parameter int  EXD_SZ  = 8,
  parameter int  CYC_SZ  = 6,
  parameter logic [TSK_NUM*PC_SZ-1:0] START_PC_ARY = '0,
  parameter logic [TSK_NUM*PC_SZ-1:0] END_PC_ARY   = '0,
  parameter int  PREEMPT = 0,
  localparam int ID_SZ   = (TSK_NUM > 1) ? $clog2(TSK_NUM) : 1
) (
  input  logic               pclk,
  input  logic               prst_n,
  input  logic [TSK_NUM-1:0] cu_tsk_trg,
  input  logic [1:0]         opcode,
  input  logic               cu_stall,
  output logic [PC_SZ-1:0]   cu_pc,
  output logic [PC_NUM-1:0]  cu_cmd_en,
  output logic               add_en,
  output logic               sub_en,
  output logic               mul_en,
  output logic               div_en,
  output logic               op_act_sm,
  output logic               op_ini_sm,
  output logic               op_rdy_sm,
  output logic               op_halt_sm,
  output logic [ID_SZ-1:0]   cu_tsk_id,
  output logic [TSK_NUM-1:0] cu_tsk_pend,
  output logic [TSK_NUM-1:0] cu_tsk_end,
  output logic               cu_tsk_done
);

  localparam logic PRE_EN = (PREEMPT != 0);

  state_t            state;
  logic [CYC_SZ-1:0] cnt;
  logic              busy;
  logic              disp_go;
  logic              disp_vld;
  logic [ID_SZ-1:0]  disp_id;
  logic [PC_SZ-1:0]  start_pc;
  logic [PC_SZ-1:0]  end_pc;
  logic              op_final;

  assign add_en = (opcode == OP_ADD);
  assign sub_en = (opcode == OP_SUB);
  assign mul_en = (opcode == OP_MUL);
  assign div_en = (opcode == OP_DIV);

  assign op_ini_sm  = state[S_INI];
  assign op_act_sm  = state[S_ONGO];
  assign op_rdy_sm  = state[S_RDY];
  assign op_halt_sm = state[S_HALT];

  assign busy     = state[S_INI] | state[S_ONGO] | state[S_RDY] | state[S_HALT];
  assign disp_go  = ~cu_stall & (state[S_IDLE] | state[S_END] | (PRE_EN & busy));
  assign start_pc = START_PC_ARY[PC_SZ*disp_id +: PC_SZ];
  assign end_pc   = END_PC_ARY[PC_SZ*cu_tsk_id +: PC_SZ];

  // cnt is 0 in INI and counts ONGO cycles, so mul spends exactly ALU_SZ cycles in INI+ONGO.
  assign op_final = ((add_en | sub_en) & state[S_INI])
                  | (mul_en & (cnt == CYC_SZ'(ALU_SZ - 1)))
                  | (div_en & (cnt == CYC_SZ'(ALU_SZ + EXD_SZ - 1)));

  ip_cu_arb #(.TSK_NUM(TSK_NUM)) u_arb (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .trg      (cu_tsk_trg),
    .disp_go  (disp_go),
    .new_only (busy),
    .pend     (cu_tsk_pend),
    .disp_vld (disp_vld),
    .disp_id  (disp_id)
  );

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cu_pc       <= '1;
      cu_cmd_en   <= '0;
      cu_tsk_id   <= '0;
      cu_tsk_end  <= '0;
      cu_tsk_done <= 1'b0;
    end else begin
      if (|cu_tsk_trg) cu_tsk_done <= 1'b0;
      if (!cu_stall) begin
        cu_tsk_end <= '0;
        cnt        <= '0;
        if (disp_vld) begin
          state     <= ST_INI;
          cu_tsk_id <= disp_id;
          cu_pc     <= start_pc;
          cu_cmd_en <= PC_NUM'(1) << start_pc;
        end else begin
          case (state)
            ST_INI, ST_ONGO: begin
              if (op_final) begin
                state <= ST_RDY;
              end else begin
                state <= ST_ONGO;
                cnt   <= cnt + 1'b1;
              end
            end
            ST_RDY: begin
              if (cu_pc == end_pc) begin
                state      <= ST_END;
                cu_tsk_end <= TSK_NUM'(1) << cu_tsk_id;
              end else begin
                state <= ST_HALT;
              end
            end
            ST_HALT: begin
              state     <= ST_INI;
              cu_pc     <= cu_pc + 1'b1;
              cu_cmd_en <= PC_NUM'(1) << (cu_pc + 1'b1);
            end
            ST_END: begin
              state       <= ST_IDLE;
              cu_pc       <= '1;
              cu_cmd_en   <= '0;
              cu_tsk_done <= 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ip_cu_seq.sv
// Directed bench: queued (d0) and preempting (d1) sequencers driven by shared stimulus.
module tb_ip_cu_seq;
  import ip_cu_pkg::*;

  logic        pclk;
  logic        prst_n;
  logic [2:0]  trg;
  logic        trg_x;
  logic [1:0]  opcode;
  logic        stall;

  logic [3:0]  d0_pc, d1_pc;
  logic [15:0] d0_cmd_en, d1_cmd_en;
  logic        d0_add, d0_sub, d0_mul, d0_div, d1_add, d1_sub, d1_mul, d1_div;
  logic        d0_act, d0_ini, d0_rdy, d0_halt, d1_act, d1_ini, d1_rdy, d1_halt;
  logic [1:0]  d0_id, d1_id;
  logic [2:0]  d0_pend, d0_tend;
  logic [3:0]  d1_pend, d1_tend;
  logic        d0_done, d1_done;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  int e0_d0, e2_d0, e0_d1, e2_d1;
  logic [3:0] exp1 [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 15};
  logic [3:0] exp_fl;

  ip_cu_seq #(
    .TSK_NUM(3), .PC_SZ(4), .PC_NUM(16), .ALU_SZ(4), .EXD_SZ(2), .CYC_SZ(3),
    .START_PC_ARY({4'd8, 4'd4, 4'd0}), .END_PC_ARY({4'd9, 4'd7, 4'd3}), .PREEMPT(0)
  ) dut0 (
    .pclk(pclk), .prst_n(prst_n), .cu_tsk_trg(trg), .opcode(opcode), .cu_stall(stall),
    .cu_pc(d0_pc), .cu_cmd_en(d0_cmd_en),
    .add_en(d0_add), .sub_en(d0_sub), .mul_en(d0_mul), .div_en(d0_div),
    .op_act_sm(d0_act), .op_ini_sm(d0_ini), .op_rdy_sm(d0_rdy), .op_halt_sm(d0_halt),
    .cu_tsk_id(d0_id), .cu_tsk_pend(d0_pend), .cu_tsk_end(d0_tend), .cu_tsk_done(d0_done)
  );

  ip_cu_seq #(
    .TSK_NUM(4), .PC_SZ(4), .PC_NUM(16), .ALU_SZ(4), .EXD_SZ(2), .CYC_SZ(3),
    .START_PC_ARY({4'd14, 4'd8, 4'd4, 4'd0}), .END_PC_ARY({4'd15, 4'd9, 4'd7, 4'd3}), .PREEMPT(1)
  ) dut1 (
    .pclk(pclk), .prst_n(prst_n), .cu_tsk_trg({trg_x, trg}), .opcode(opcode), .cu_stall(stall),
    .cu_pc(d1_pc), .cu_cmd_en(d1_cmd_en),
    .add_en(d1_add), .sub_en(d1_sub), .mul_en(d1_mul), .div_en(d1_div),
    .op_act_sm(d1_act), .op_ini_sm(d1_ini), .op_rdy_sm(d1_rdy), .op_halt_sm(d1_halt),
    .cu_tsk_id(d1_id), .cu_tsk_pend(d1_pend), .cu_tsk_end(d1_tend), .cu_tsk_done(d1_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int c = 0;
    while (!d0_done && c < lim) begin
      step();
      c++;
    end
    chk(tag, d0_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    prst_n = 1'b0; trg = '0; trg_x = 1'b0; opcode = OP_ADD; stall = 1'b0;
    repeat (3) @(posedge pclk);
    #3 prst_n = 1'b1;
    #1;
    chk("rst_pc", d0_pc, 4'hF);
    chk("rst_cmd_en", d0_cmd_en, 0);
    chk("rst_flags", {d0_ini, d0_act, d0_rdy, d0_halt}, 0);
    chk("rst_pend_end_done", {d0_pend, d0_tend, d0_done}, 0);
    step();

    // Single add task: INI, RDY, HALT per command, END, then IDLE with done.
    trg = 3'b001;
    for (int k = 1; k <= 13; k++) begin
      step();
      trg = '0;
      exp_fl = (k >= 12) ? 4'b0000 : ((k - 1) % 3 == 0) ? 4'b1000 : ((k - 1) % 3 == 1) ? 4'b0010 : 4'b0001;
      chk($sformatf("t1_pc_k%0d", k), d0_pc, exp1[k-1]);
      chk($sformatf("t1_fl_k%0d", k), {d0_ini, d0_act, d0_rdy, d0_halt}, exp_fl);
      if (k == 4)  chk("t1_cmd_en_pc1", d0_cmd_en, 16'h0002);
      if (k == 11) chk("t1_no_end_yet", d0_tend, 0);
      if (k == 12) chk("t1_end_pulse", d0_tend, 3'b001);
      if (k == 13) begin
        chk("t1_end_clr", d0_tend, 0);
        chk("t1_done", d0_done, 1);
        chk("t1_cmd_idle", d0_cmd_en, 0);
      end
    end

    // Two simultaneous triggers: task1 then task2, done only after task2.
    trg = 3'b110;
    for (int k = 1; k <= 19; k++) begin
      step();
      trg = '0;
      if (k == 1) begin
        chk("t3_done_clr", d0_done, 0);
        chk("t3_id1", d0_id, 1);
        chk("t3_pc4", d0_pc, 4);
        chk("t3_pend", d0_pend, 3'b100);
      end
      if (k == 12) chk("t3_end1", {d0_tend, d0_done}, 4'b0100);
      if (k == 13) chk("t3_task2_start", {d0_id, d0_pc, d0_pend, d0_done}, {2'd2, 4'd8, 3'b000, 1'b0});
      if (k == 18) chk("t3_end2", d0_tend, 3'b100);
      if (k == 19) chk("t3_done", d0_done, 1);
    end

    // Opcode decode and mul/div latency.
    opcode = OP_DIV; #1;
    chk("dec_div", {d0_add, d0_sub, d0_mul, d0_div}, 4'b0001);
    opcode = OP_SUB; #1;
    chk("dec_sub", {d0_add, d0_sub, d0_mul, d0_div}, 4'b0100);
    opcode = OP_MUL; #1;
    chk("dec_mul", {d0_add, d0_sub, d0_mul, d0_div}, 4'b0010);
    step();
    trg = 3'b100;
    step();
    trg = '0;
    n = 0;
    for (int k = 0; k < 40 && !d0_rdy; k++) begin
      if (d0_ini || d0_act) n++;
      step();
    end
    chk("t2_mul_cycles", n, 4);
    wait_done(100, "t2_mul_done");
    opcode = OP_DIV;
    trg = 3'b100;
    step();
    trg = '0;
    n = 0;
    for (int k = 0; k < 40 && !d0_rdy; k++) begin
      if (d0_ini || d0_act) n++;
      step();
    end
    chk("t2_div_cycles", n, 6);
    wait_done(100, "t2_div_done");

    // Trigger task0 while task2 is in ONGO: d0 queues it, d1 preempts.
    opcode = OP_MUL;
    trg = 3'b100;
    step();
    trg = '0;
    step();
    chk("t4_ongo", {d0_act, d1_act}, 2'b11);
    trg = 3'b001;
    step();
    trg = '0;
    chk("t4_d0_keeps", {d0_act, d0_pc, d0_pend}, {1'b1, 4'd8, 3'b001});
    chk("t4_d1_preempt", {d1_ini, d1_pc, d1_id, d1_pend, d1_tend}, {1'b1, 4'd0, 2'd0, 4'b0000, 4'b0000});
    e0_d0 = 0; e2_d0 = 0; e0_d1 = 0; e2_d1 = 0;
    for (int k = 4; k <= 45; k++) begin
      step();
      if (d0_tend[0] && e0_d0 == 0) e0_d0 = k;
      if (d0_tend[2] && e2_d0 == 0) e2_d0 = k;
      if (d1_tend[0] && e0_d1 == 0) e0_d1 = k;
      if (d1_tend[2] && e2_d1 == 0) e2_d1 = k;
    end
    chk("t4_d0_end2_cyc", e2_d0, 12);
    chk("t4_d0_end0_cyc", e0_d0, 36);
    chk("t4_d1_end0_cyc", e0_d1, 26);
    chk("t4_d1_no_end2", e2_d1, 0);
    chk("t4_both_done", {d0_done, d1_done}, 2'b11);

    // Stall in ONGO for 5 cycles, trigger captured meanwhile; stalled END holds its pulse.
    trg = 3'b100;
    step();
    trg = '0;
    step();
    stall = 1'b1;
    trg = 3'b010;
    for (int k = 3; k <= 7; k++) begin
      step();
      trg = '0;
      chk($sformatf("t5_frozen_k%0d", k), {d0_act, d0_pc}, {1'b1, 4'd8});
      if (k == 3) chk("t5_pend", d0_pend, 3'b010);
    end
    stall = 1'b0;
    step();
    step();
    chk("t5_not_rdy_k9", d0_rdy, 0);
    step();
    chk("t5_rdy_k10", d0_rdy, 1);
    for (int k = 11; k <= 17; k++) step();
    chk("t5_end_k17", d0_tend, 3'b100);
    stall = 1'b1;
    step();
    chk("t5_end_hold_k18", d0_tend, 3'b100);
    step();
    chk("t5_end_hold_k19", d0_tend, 3'b100);
    stall = 1'b0;
    step();
    chk("t5_released", {d0_tend, d0_pc, d0_id}, {3'b000, 4'd4, 2'd1});

    // Asynchronous reset mid-task with a pending trigger.
    trg = 3'b001;
    step();
    trg = '0;
    chk("t6_pend_before", d0_pend, 3'b001);
    #2 prst_n = 1'b0;
    #1;
    chk("t6_pc", d0_pc, 4'hF);
    chk("t6_cmd_en", d0_cmd_en, 0);
    chk("t6_pend", d0_pend, 0);
    chk("t6_idle", {d0_ini, d0_act, d0_rdy, d0_halt, d0_tend, d0_id}, 0);
    @(negedge pclk);
    prst_n = 1'b1;
    step();

    // Task ending on the top PC value (d1 task3: 14..15).
    opcode = OP_ADD;
    trg_x = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      trg_x = 1'b0;
      if (k == 1) chk("t7_start", {d1_pc, d1_id}, {4'd14, 2'd3});
      if (k == 4) chk("t7_pc15", {d1_pc, d1_cmd_en}, {4'd15, 16'h8000});
      if (k == 6) chk("t7_end3", d1_tend, 4'b1000);
      if (k == 7) chk("t7_idle", {d1_pc, d1_cmd_en, d1_done}, {4'hF, 16'h0000, 1'b1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
